// File: rtl/fifo_chk_pkg.sv
// Shared types and constants for the FIFO read-side checker and its LFSR.
package fifo_chk_pkg;
   localparam int CNT_W = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/fifo_chk_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous load and enable.
module fifo_chk_lfsr
   import fifo_chk_pkg::*;
#(
   parameter logic [15:0] INIT = 16'hACE1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic bit0
);
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= INIT;
      end else if (load) begin
         lfsr <= INIT;
      end else if (en) begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign bit0 = lfsr[0];
endmodule

// File: rtl/fifo_rd_chk.sv
// Read-side FIFO checker: pops an incrementing pattern, counts errors and stalls,
// and reports pass/timeout when the run ends.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RD    | popping words; LFSR runs, stall counter armed
// DONE  | run finished (count reached or timeout); results held
module fifo_rd_chk
   import fifo_chk_pkg::*;
#(
   parameter int              DSIZE       = 8,
   parameter int              RD_NUM      = 256,
   parameter logic [DSIZE-1:0] SEED       = '0,
   parameter bit              THROTTLE_EN = 1'b1,
   parameter logic [15:0]     LFSR_INIT   = 16'hACE1,
   parameter int              TIMEOUT     = 1024
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             start,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [DSIZE-1:0] first_err_data
);
   localparam logic [CNT_W-1:0] RD_NUM_C  = CNT_W'(RD_NUM);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state;
   logic [DSIZE-1:0] exp;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] stall_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic             lfsr_bit;
   logic             go;
   logic             mismatch;

   assign go        = start && (state != RD);
   assign busy      = (state == RD);
   assign mismatch  = (rdata != exp);
   assign stall_nxt = stall_cnt + 16'd1;
   assign err_nxt   = (mismatch && (err_cnt != '1)) ? err_cnt + 16'd1 : err_cnt;
   assign rinc      = (state == RD) && !rempty && (lfsr_bit || !THROTTLE_EN)
                      && (rd_cnt < RD_NUM_C);

   fifo_chk_lfsr #(.INIT(LFSR_INIT)) u_lfsr (
      .clk   (rclk),
      .rst_n (rrst_n),
      .load  (go),
      .en    (state == RD),
      .bit0  (lfsr_bit)
   );

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state          <= IDLE;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         rd_cnt         <= '0;
         err_cnt        <= '0;
         first_err_data <= '0;
         exp            <= SEED;
         stall_cnt      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= RD;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  timeout        <= 1'b0;
                  rd_cnt         <= '0;
                  err_cnt        <= '0;
                  first_err_data <= '0;
                  exp            <= SEED;
                  stall_cnt      <= '0;
               end
            end
            RD: begin
               if (rinc) begin
                  rd_cnt  <= rd_cnt + 16'd1;
                  exp     <= exp + 1'b1;
                  err_cnt <= err_nxt;
                  if (mismatch && (err_cnt == '0)) begin
                     first_err_data <= rdata;
                  end
               end
               // A pop needs rempty=0, so the timeout and final-pop exits never collide.
               if (rempty) begin
                  stall_cnt <= stall_nxt;
                  if (stall_nxt == TIMEOUT_C) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     timeout <= 1'b1;
                     pass    <= 1'b0;
                  end
               end else begin
                  stall_cnt <= '0;
               end
               if (rinc && ((rd_cnt + 16'd1) == RD_NUM_C)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
